riscv_mem_arbiter: RTL
======================

// Module: riscv_mem_arbiter
// PURPOSE
//  Shares one memory port between riscv_cpu instruction fetch (I) and load/store (D).
//  Uses a req/ack handshake on both sides and registers all memory-side outputs.
//  D has priority; a starvation guard forces an I grant after STARVE_MAX back-to-back D grants.
//  A per-transaction timeout completes hung accesses with an error flag.
//  Sits between the CPU core and the shared instruction/data/GPIO memory.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width (byte enables are DW/8 bits)
//  STARVE_MAX  4   consecutive D grants, with i_req pending, before I is forced; min 1
//  TIMEOUT     64  cycles in BUSY without m_ack before abort; 0 disables the timeout
// PORTS
//  clk      in   1      clock, rising edge
//  rst      in   1      asynchronous, active-low reset
//  i_req    in   1      fetch request; held with i_addr until i_ack
//  i_addr   in   AW     fetch address
//  i_ack    out  1      1-cycle pulse: fetch done, i_rdata/i_err valid
//  i_rdata  out  DW     fetch data (registered)
//  i_err    out  1      fetch timed out (valid with i_ack)
//  d_req    in   1      load/store request; held with d_* fields until d_ack
//  d_we     in   1      1 = store
//  d_addr   in   AW     data address
//  d_wdata  in   DW     store data
//  d_be     in   DW/8   store byte enables
//  d_ack    out  1      1-cycle pulse: access done
//  d_rdata  out  DW     load data (registered)
//  d_err    out  1      access timed out (valid with d_ack)
//  m_req    out  1      memory request; held until m_ack or timeout
//  m_we     out  1      memory write enable
//  m_addr   out  AW     memory address
//  m_wdata  out  DW     memory write data
//  m_be     out  DW/8   memory byte enables (all ones on fetch)
//  m_rdata  in   DW     memory read data, valid with m_ack
//  m_ack    in   1      memory done; may arrive in the first m_req cycle
//  busy     out  1      state != IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE. All outputs 0. starve_cnt=0, tmo_cnt=0.
//  FSM states: IDLE, BUSY_I, BUSY_D, RESP.
//  IDLE: arbitration.
//   - Grant I if i_req && (!d_req || starve_cnt==STARVE_MAX); otherwise grant D if d_req.
//   - On the grant edge: latch the winner's fields into m_*, set m_req=1 and tmo_cnt=0.
//   - Next state is BUSY_I or BUSY_D.
//   - Fetch: m_we=0, m_be=all ones, m_wdata=0.
//  starve_cnt (evaluated at each grant):
//   - D grant with i_req=1: starve_cnt+1, saturating at STARVE_MAX.
//   - I grant: starve_cnt=0.
//   - D grant with i_req=0: starve_cnt=0.
//  BUSY_x:
//   - m_ack=1: m_req<=0, x_rdata<=m_rdata, x_ack<=1, x_err<=0, next RESP.
//   - Timeout: if TIMEOUT!=0 and tmo_cnt==TIMEOUT-1 with no m_ack: m_req<=0, x_rdata<=0,
//     x_ack<=1, x_err<=1, next RESP.
//   - m_ack in the same cycle as the timeout: m_ack wins, no error.
//   - Otherwise tmo_cnt+1.
//  RESP: x_ack/x_err high for exactly this cycle. No arbitration (requester still
//   holds req). Next IDLE; ack/err cleared.
//  Latency: req seen in IDLE at cycle 0; m_req high cycles 1..k (m_ack in cycle k);
//   x_ack in cycle k+1. Minimum 2 cycles req->ack; 3-cycle minimum issue interval.
//  x_rdata holds its value until the next ack to the same requester.
//  m_ack outside BUSY_x is ignored. Req changes during BUSY/RESP are ignored
//   (protocol violation; no recovery required).
//  Stores return d_ack with d_rdata = m_rdata as driven by memory (don't-care to CPU).
//  Reset mid-transaction: m_req drops immediately; no ack is issued for the aborted access.
// TESTING
//  1 Lone fetch: i_req=1, i_addr=0x100, memory acks 1 cycle after m_req with 0x00000013
//    -> m_addr=0x100, m_we=0, m_be=4'hF; i_ack one pulse, i_rdata=0x13, i_err=0.
//  2 Simultaneous I+D, d_we=1, d_addr=0x8000_0000, d_wdata=0xA5, d_be=4'h1
//    -> D granted first (m_we=1, m_be=4'h1); I granted at the next IDLE.
//  3 d_req held high and i_req held high, STARVE_MAX=4 -> grant order D,D,D,D,I,D,...
//    with no 5th consecutive D.
//  4 TIMEOUT=64, memory never acks a load -> m_req high 64 cycles, then d_ack=1,
//    d_err=1, d_rdata=0; the next transaction proceeds normally.
//  5 m_ack asserted in the timeout cycle -> normal ack, err=0.
//  6 rst pulled low in BUSY_D -> all outputs 0 asynchronously; after release, state IDLE
//    and no stale d_ack is issued.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one memory port between instruction fetch and load/store
module riscv_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_ack,
    output logic [DW-1:0]   i_rdata,
    output logic            i_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    output logic            d_err,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_ack,
    output logic            busy
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          grant_i;
    logic          tmo_hit;

    // fetch wins only when data is idle or has starved fetch long enough
    always_comb begin
        grant_i = i_req && (!d_req || starve_cnt == SW'(STARVE_MAX));
        tmo_hit = TIMEOUT != 0 && tmo_cnt == TW'(TIMEOUT - 1);
    end

    assign busy = state != IDLE;

    // arbitration, memory-side registers and response pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_be       <= '0;
            i_ack      <= 1'b0;
            i_rdata    <= '0;
            i_err      <= 1'b0;
            d_ack      <= 1'b0;
            d_rdata    <= '0;
            d_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        m_req      <= 1'b1;
                        m_we       <= 1'b0;
                        m_addr     <= i_addr;
                        m_wdata    <= '0;
                        m_be       <= '1;
                        tmo_cnt    <= '0;
                        starve_cnt <= '0;
                        state      <= BUSY_I;
                    end else if (d_req) begin
                        m_req      <= 1'b1;
                        m_we       <= d_we;
                        m_addr     <= d_addr;
                        m_wdata    <= d_wdata;
                        m_be       <= d_be;
                        tmo_cnt    <= '0;
                        starve_cnt <= !i_req ? '0 :
                                      starve_cnt == SW'(STARVE_MAX) ? starve_cnt : starve_cnt + SW'(1);
                        state      <= BUSY_D;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (m_ack || tmo_hit) begin
                        m_req <= 1'b0;
                        state <= RESP;
                        if (state == BUSY_I) begin
                            i_ack   <= 1'b1;
                            i_err   <= !m_ack;
                            i_rdata <= m_ack ? m_rdata : '0;
                        end else begin
                            d_ack   <= 1'b1;
                            d_err   <= !m_ack;
                            d_rdata <= m_ack ? m_rdata : '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                RESP: begin
                    i_ack <= 1'b0;
                    i_err <= 1'b0;
                    d_ack <= 1'b0;
                    d_err <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
